// File: rtl/aes_ctrl_pkg.sv
// Shared definitions for the AES job controller and its helpers.
// Holds the controller state encoding, the operation codes carried on
// cmd_op/rsp_op and the AES block width used for data and key buses.
package aes_ctrl_pkg;

  localparam int AES_BLOCK_W = 128;

  localparam logic OP_ENC = 1'b0;
  localparam logic OP_DEC = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } ctrl_state_e;

endpackage

// File: rtl/aes_job_timer.sv
// Watchdog counter for an engine job.
// Ports:
//   clk, reset : rising-edge clock, asynchronous active-high reset
//   clear      : force the count back to 0 (wins over enable)
//   enable     : advance the count by one this cycle
//   expire     : high in an enabled cycle whose increment brings the count
//                to LIMIT, so the owner can act in that same cycle
module aes_job_timer #(
  parameter int CNT_W = 8,
  parameter int LIMIT = 63
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // count_q still holds the pre-increment value, hence the compare with LIMIT-1.
  assign expire = enable && !clear && (count_q == LAST);

endmodule

// File: rtl/aes_job_controller.sv
// Sequencer in front of the AES encrypt/decrypt engines.
// Takes one job at a time on the cmd_* valid/ready channel, pulses the
// matching engine start for one cycle, waits for that engine's done (or a
// watchdog timeout) and returns the result with tag/op/status on rsp_*.
// Ports:
//   clk, reset                : clock, asynchronous active-high reset
//   cmd_valid/ready, cmd_op/data/key/tag : command channel
//   core_data, core_key       : registered job data/key to both engines
//   core_start_enc/dec        : one-cycle start pulses
//   core_done_enc/dec, core_cipher/plain : engine completion and results
//   rsp_valid/ready, rsp_data/op/tag/timeout : response channel
//   busy                      : controller is not idle
module aes_job_controller
  import aes_ctrl_pkg::*;
#(
  parameter int TAG_W          = 4,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   cmd_op,
  input  logic [AES_BLOCK_W-1:0] cmd_data,
  input  logic [AES_BLOCK_W-1:0] cmd_key,
  input  logic [TAG_W-1:0]       cmd_tag,
  output logic [AES_BLOCK_W-1:0] core_data,
  output logic [AES_BLOCK_W-1:0] core_key,
  output logic                   core_start_enc,
  output logic                   core_start_dec,
  input  logic                   core_done_enc,
  input  logic                   core_done_dec,
  input  logic [AES_BLOCK_W-1:0] core_cipher,
  input  logic [AES_BLOCK_W-1:0] core_plain,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [AES_BLOCK_W-1:0] rsp_data,
  output logic                   rsp_op,
  output logic [TAG_W-1:0]       rsp_tag,
  output logic                   rsp_timeout,
  output logic                   busy
);

  ctrl_state_e            state_q, state_d;
  logic                   cmd_ready_q, cmd_ready_d;
  logic                   op_q, op_d;
  logic [AES_BLOCK_W-1:0] data_q, data_d;
  logic [AES_BLOCK_W-1:0] key_q, key_d;
  logic [TAG_W-1:0]       tag_q, tag_d;
  logic [AES_BLOCK_W-1:0] rsp_data_q, rsp_data_d;
  logic                   rsp_timeout_q, rsp_timeout_d;

  logic                   sel_done;
  logic [AES_BLOCK_W-1:0] sel_result;
  logic                   timer_expire;

  // Only the engine that owns the current job can complete it.
  assign sel_done   = (op_q == OP_DEC) ? core_done_dec : core_done_enc;
  assign sel_result = (op_q == OP_DEC) ? core_plain    : core_cipher;

  aes_job_timer #(
    .CNT_W (CNT_W),
    .LIMIT (TIMEOUT_CYCLES - 1)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (state_q == LAUNCH),
    .enable (state_q == WAIT),
    .expire (timer_expire)
  );

  // cmd_ready is registered from the next state so it is 0 while reset is
  // held and rises on the first clock edge after release.
  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    data_d        = data_q;
    key_d         = key_q;
    tag_d         = tag_q;
    rsp_data_d    = rsp_data_q;
    rsp_timeout_d = rsp_timeout_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          op_d    = cmd_op;
          data_d  = cmd_data;
          key_d   = cmd_key;
          tag_d   = cmd_tag;
          state_d = LAUNCH;
        end
      end
      LAUNCH: begin
        state_d = WAIT;
      end
      WAIT: begin
        // done is checked first so it wins over a coincident expiry
        if (sel_done) begin
          rsp_data_d    = sel_result;
          rsp_timeout_d = 1'b0;
          state_d       = RESP;
        end else if (timer_expire) begin
          rsp_data_d    = '0;
          rsp_timeout_d = 1'b1;
          state_d       = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    cmd_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      cmd_ready_q   <= 1'b0;
      op_q          <= 1'b0;
      data_q        <= '0;
      key_q         <= '0;
      tag_q         <= '0;
      rsp_data_q    <= '0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cmd_ready_q   <= cmd_ready_d;
      op_q          <= op_d;
      data_q        <= data_d;
      key_q         <= key_d;
      tag_q         <= tag_d;
      rsp_data_q    <= rsp_data_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign cmd_ready      = cmd_ready_q;
  assign core_data      = data_q;
  assign core_key       = key_q;
  assign core_start_enc = (state_q == LAUNCH) && (op_q == OP_ENC);
  assign core_start_dec = (state_q == LAUNCH) && (op_q == OP_DEC);
  assign rsp_valid      = (state_q == RESP);
  assign rsp_data       = rsp_data_q;
  assign rsp_op         = op_q;
  assign rsp_tag        = tag_q;
  assign rsp_timeout    = rsp_timeout_q;
  assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_aes_job_controller.sv
// Directed testbench for aes_job_controller with a behavioural engine stub
// that answers the FIPS-197 AES-128 example vector after a set latency.
module tb_aes_job_controller;

  localparam logic [127:0] KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic         clk;
  logic         reset;
  logic         cmd_valid;
  logic         cmd_ready;
  logic         cmd_op;
  logic [127:0] cmd_data;
  logic [127:0] cmd_key;
  logic [3:0]   cmd_tag;
  logic [127:0] core_data;
  logic [127:0] core_key;
  logic         core_start_enc;
  logic         core_start_dec;
  logic         core_done_enc;
  logic         core_done_dec;
  logic [127:0] core_cipher;
  logic [127:0] core_plain;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [127:0] rsp_data;
  logic         rsp_op;
  logic [3:0]   rsp_tag;
  logic         rsp_timeout;
  logic         busy;

  int num_checks = 0;
  int num_errors = 0;

  aes_job_controller dut (
    .clk            (clk),
    .reset          (reset),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_op         (cmd_op),
    .cmd_data       (cmd_data),
    .cmd_key        (cmd_key),
    .cmd_tag        (cmd_tag),
    .core_data      (core_data),
    .core_key       (core_key),
    .core_start_enc (core_start_enc),
    .core_start_dec (core_start_dec),
    .core_done_enc  (core_done_enc),
    .core_done_dec  (core_done_dec),
    .core_cipher    (core_cipher),
    .core_plain     (core_plain),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_data       (rsp_data),
    .rsp_op         (rsp_op),
    .rsp_tag        (rsp_tag),
    .rsp_timeout    (rsp_timeout),
    .busy           (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Engine stub: a start arms it, and after stub_latency edges it pulses the
  // matching done with the known-answer result. stub_hang keeps it silent.
  int           stub_latency = 1;
  logic         stub_hang = 1'b0;
  logic         force_done_enc = 1'b0;
  logic         stub_pend;
  logic         stub_pend_dec;
  int           stub_cnt;
  logic         stub_done_enc;
  logic         stub_done_dec;

  function automatic logic [127:0] engineModel(input logic [127:0] d, input logic dec);
    if (!dec) return (d == PT) ? CT : ~d;
    return (d == CT) ? PT : ~d;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      stub_pend     <= 1'b0;
      stub_pend_dec <= 1'b0;
      stub_cnt      <= 0;
      stub_done_enc <= 1'b0;
      stub_done_dec <= 1'b0;
      core_cipher   <= '0;
      core_plain    <= '0;
    end else begin
      stub_done_enc <= 1'b0;
      stub_done_dec <= 1'b0;
      if (core_start_enc || core_start_dec) begin
        stub_pend     <= 1'b1;
        stub_pend_dec <= core_start_dec;
        stub_cnt      <= stub_latency - 1;
      end else if (stub_pend && !stub_hang) begin
        if (stub_cnt == 0) begin
          stub_pend <= 1'b0;
          if (stub_pend_dec) begin
            stub_done_dec <= 1'b1;
            core_plain    <= engineModel(core_data, 1'b1);
          end else begin
            stub_done_enc <= 1'b1;
            core_cipher   <= engineModel(core_data, 1'b0);
          end
        end else begin
          stub_cnt <= stub_cnt - 1;
        end
      end
    end
  end

  assign core_done_enc = stub_done_enc | force_done_enc;
  assign core_done_dec = stub_done_dec;

  // Start pulse monitor
  int enc_pulses = 0;
  int dec_pulses = 0;
  bit both_seen  = 1'b0;

  always @(negedge clk) begin
    if (!reset) begin
      if (core_start_enc) enc_pulses++;
      if (core_start_dec) dec_pulses++;
      if (core_start_enc && core_start_dec) both_seen = 1'b1;
    end
  end

  task automatic checkOutput(input string tag, input logic [127:0] actual, input logic [127:0] expected);
    num_checks++;
    if (actual !== expected) begin
      num_errors++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  task automatic checkResetState(input string pfx);
    checkOutput({pfx, "_ctrl"},
                128'({cmd_ready, core_start_enc, core_start_dec, rsp_valid, rsp_op, rsp_timeout, busy, rsp_tag}),
                128'd0);
    checkOutput({pfx, "_core_data"}, core_data, 128'd0);
    checkOutput({pfx, "_core_key"}, core_key, 128'd0);
    checkOutput({pfx, "_rsp_data"}, rsp_data, 128'd0);
  endtask

  // Waits (bounded) for cmd_ready, then completes the handshake and leaves
  // the caller just after the accepting edge, i.e. in the LAUNCH cycle.
  task automatic waitAccept();
    int n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) checkOutput("cmd_accept_wait", 128'(cmd_ready), 128'd1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic applyStimulus(input logic op, input logic [127:0] data, input logic [127:0] key, input logic [3:0] tag);
    cmd_op    = op;
    cmd_data  = data;
    cmd_key   = key;
    cmd_tag   = tag;
    cmd_valid = 1'b1;
    waitAccept();
  endtask

  // Called in the LAUNCH cycle; lat counts negedges from the start pulse
  // until rsp_valid is seen, then the response is taken.
  task automatic collectResponse(input bit drop_force, output logic [127:0] r_data, output logic r_op,
                                 output logic [3:0] r_tag, output logic r_to, output int lat);
    @(negedge clk);
    if (drop_force) begin
      @(posedge clk);
      #1 force_done_enc = 1'b0;
    end
    lat = 0;
    while (!rsp_valid && lat < 300) begin
      @(negedge clk);
      lat++;
    end
    if (!rsp_valid) checkOutput("rsp_wait", 128'(rsp_valid), 128'd1);
    r_data = rsp_data;
    r_op   = rsp_op;
    r_tag  = rsp_tag;
    r_to   = rsp_timeout;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
  endtask

  task automatic runJob(input logic op, input logic [127:0] data, input logic [3:0] tag, input int latency,
                        input bit drop_force, output logic [127:0] r_data, output logic r_op,
                        output logic [3:0] r_tag, output logic r_to, output int lat);
    stub_latency = latency;
    applyStimulus(op, data, KEY, tag);
    collectResponse(drop_force, r_data, r_op, r_tag, r_to, lat);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [127:0] r_data;
    logic         r_op;
    logic [3:0]   r_tag;
    logic         r_to;
    logic [127:0] snap_data;
    int           lat;
    int           e0;
    int           d0;
    bit           ok;
    bit           extra;

    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 1'b0;
    cmd_data  = '0;
    cmd_key   = '0;
    cmd_tag   = '0;
    rsp_ready = 1'b0;

    repeat (3) @(negedge clk);
    checkResetState("reset");
    reset = 1'b0;

    $display("[TB] encrypt job");
    e0 = enc_pulses;
    d0 = dec_pulses;
    runJob(1'b0, PT, 4'd3, 6, 1'b0, r_data, r_op, r_tag, r_to, lat);
    checkOutput("enc_data", r_data, CT);
    checkOutput("enc_tag", 128'(r_tag), 128'd3);
    checkOutput("enc_op", 128'(r_op), 128'd0);
    checkOutput("enc_timeout", 128'(r_to), 128'd0);
    checkOutput("enc_latency", 128'(lat), 128'd8);
    checkOutput("enc_start_pulses", 128'(enc_pulses - e0), 128'd1);
    checkOutput("enc_no_dec_pulse", 128'(dec_pulses - d0), 128'd0);
    checkOutput("core_data_held", core_data, PT);
    checkOutput("core_key_held", core_key, KEY);

    $display("[TB] decrypt job");
    e0 = enc_pulses;
    d0 = dec_pulses;
    runJob(1'b1, CT, 4'd5, 3, 1'b0, r_data, r_op, r_tag, r_to, lat);
    checkOutput("dec_data", r_data, PT);
    checkOutput("dec_tag", 128'(r_tag), 128'd5);
    checkOutput("dec_op", 128'(r_op), 128'd1);
    checkOutput("dec_start_pulses", 128'(dec_pulses - d0), 128'd1);
    checkOutput("dec_no_enc_pulse", 128'(enc_pulses - e0), 128'd0);

    $display("[TB] response backpressure");
    stub_latency = 3;
    applyStimulus(1'b0, PT, KEY, 4'd7);
    lat = 0;
    while (!rsp_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    snap_data = rsp_data;
    checkOutput("bp_first_data", snap_data, CT);
    cmd_op    = 1'b1;
    cmd_data  = CT;
    cmd_key   = KEY;
    cmd_tag   = 4'd9;
    cmd_valid = 1'b1;
    d0 = dec_pulses;
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!rsp_valid || rsp_data !== snap_data || rsp_tag !== 4'd7 || rsp_op !== 1'b0 ||
          rsp_timeout !== 1'b0 || cmd_ready !== 1'b0 || core_start_dec !== 1'b0) ok = 1'b0;
    end
    checkOutput("bp_stable", 128'(ok), 128'd1);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    @(negedge clk);
    checkOutput("bp_idle_after_hs", 128'({cmd_ready, busy, rsp_valid}), 128'b100);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    collectResponse(1'b0, r_data, r_op, r_tag, r_to, lat);
    checkOutput("bp_second_data", r_data, PT);
    checkOutput("bp_second_tag", 128'(r_tag), 128'd9);
    checkOutput("bp_second_dec_pulse", 128'(dec_pulses - d0), 128'd1);

    $display("[TB] timeout");
    stub_hang = 1'b1;
    runJob(1'b0, PT, 4'd2, 1, 1'b0, r_data, r_op, r_tag, r_to, lat);
    stub_hang = 1'b0;
    checkOutput("to_latency", 128'(lat), 128'd64);
    checkOutput("to_flag", 128'(r_to), 128'd1);
    checkOutput("to_data", r_data, 128'd0);
    checkOutput("to_tag", 128'(r_tag), 128'd2);

    runJob(1'b0, PT, 4'd4, 62, 1'b0, r_data, r_op, r_tag, r_to, lat);
    checkOutput("coinc_latency", 128'(lat), 128'd64);
    checkOutput("coinc_flag", 128'(r_to), 128'd0);
    checkOutput("coinc_data", r_data, CT);

    $display("[TB] stale and foreign done");
    force_done_enc = 1'b1;
    runJob(1'b1, CT, 4'd6, 5, 1'b0, r_data, r_op, r_tag, r_to, lat);
    checkOutput("foreign_latency", 128'(lat), 128'd7);
    checkOutput("foreign_data", r_data, PT);
    runJob(1'b0, PT, 4'd8, 4, 1'b1, r_data, r_op, r_tag, r_to, lat);
    checkOutput("stale_latency", 128'(lat), 128'd6);
    checkOutput("stale_data", r_data, CT);
    checkOutput("stale_tag", 128'(r_tag), 128'd8);

    $display("[TB] reset during WAIT");
    stub_latency = 20;
    applyStimulus(1'b0, PT, KEY, 4'd1);
    @(negedge clk);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    #1 checkResetState("midrst");
    @(negedge clk);
    reset = 1'b0;
    runJob(1'b1, CT, 4'd11, 2, 1'b0, r_data, r_op, r_tag, r_to, lat);
    checkOutput("postrst_data", r_data, PT);
    checkOutput("postrst_tag", 128'(r_tag), 128'd11);
    checkOutput("postrst_op", 128'(r_op), 128'd1);
    extra = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rsp_valid) extra = 1'b1;
    end
    checkOutput("postrst_no_extra_rsp", 128'(extra), 128'd0);
    checkOutput("never_both_starts", 128'(both_seen), 128'd0);

    $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
    $finish;
  end

endmodule
